mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sequencer between the multicycle controller and the asynchronous word memory (8-bit words, 32 entries, 5-bit address).
- Selects the instruction or data address and holds address/data stable around a single-cycle read or write strobe.
- Captures read data into the instruction register (IR) or the memory data register (MDR).
- Gives the controller a start/done handshake, so the memory never sees strobes while its address is changing.

Parameters:
- WORD, 8, memory word width and IR/MDR width
- ADDRESSL, 5, memory address width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request pulse from controller; sampled only in IDLE
- kind  input  2  00 fetch (address = pc, into IR); 01 load (address = data_addr, into MDR); 10 store (address = data_addr, write store_data); 11 reserved
- pc  input  ADDRESSL  instruction address
- data_addr  input  ADDRESSL  data address
- store_data  input  WORD  store payload
- mem_address  output  ADDRESSL  to memory address
- mem_write_data  output  WORD  to memory writeData
- mem_read  output  1  to memory memRead
- mem_write  output  1  to memory memWrite
- mem_read_data  input  WORD  from memory readData
- ir  output  WORD  instruction register
- mdr  output  WORD  memory data register
- busy  output  1  high while not IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- States: IDLE, SETUP, ACCESS, CAPTURE.
  - IDLE -> SETUP when start=1 and kind!=11.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> CAPTURE unconditionally.
  - CAPTURE -> IDLE unconditionally.
- Accept edge: on the edge where IDLE accepts start, latch the following, all held constant until the next accepted request:
  - kind;
  - mem_address = pc for fetch, data_addr otherwise;
  - mem_write_data = store_data for a store; unchanged for fetch/load.
- Timing, with start sampled at edge T:
  - SETUP: cycle T+1; address valid, both strobes low.
  - ACCESS: cycle T+2; mem_read=1 for fetch/load, mem_write=1 for store, the other strobe 0.
  - CAPTURE: cycle T+3; strobes low, done=1.
  - IDLE again at T+4.
- Capture: on the edge ending ACCESS:
  - fetch: ir <= mem_read_data;
  - load: mdr <= mem_read_data;
  - store: ir and mdr unchanged.
  - ir/mdr therefore show new data during CAPTURE (same cycle as done).
- Each strobe is high for exactly one cycle per request; mem_read and mem_write are never high together.
- mem_address is never changed while either strobe is high, nor in the cycles adjacent to a strobe.
- busy = 1 in SETUP, ACCESS, CAPTURE; done = 1 only in CAPTURE.
- start while busy (including CAPTURE) is ignored: no queueing, no error.
- start in IDLE with kind=11 is ignored: stays IDLE, no strobe, no done.
- Back-to-back: start asserted in the first IDLE cycle after CAPTURE is accepted, giving a minimum 4-cycle request period.
- Changes to pc/data_addr/store_data after acceptance have no effect on the request in flight.
- Reset (synchronous, any state including mid-ACCESS):
  - next state IDLE;
  - mem_address=0, mem_write_data=0, ir=0, mdr=0;
  - from the cycle after the reset edge: mem_read=0, mem_write=0, busy=0, done=0.
  - An in-flight request is abandoned: no capture occurs if rst is high on the edge ending ACCESS.
- Widths: every address and data path is exact width; no arithmetic is performed.

Decomposition:
- Shared package (cpu_pkg):
  - access-kind constants KIND_FETCH=2'b00, KIND_LOAD=2'b01, KIND_STORE=2'b10, KIND_RSVD=2'b11;
  - state encoding S_IDLE/S_SETUP/S_ACCESS/S_CAPTURE;
  - WORD/ADDRESSL defaults.
- Single module; no sub-module needed.
- Integration bench instantiates the memory with a known data image as the slave.

Test Plan:
- Fetch: memory[3]=8'hA5, pc=3, kind=00, start pulse at T -> mem_read high only at T+2 with mem_address=3; ir=8'hA5 and done=1 at T+3; mdr unchanged; busy low at T+4.
- Load: memory[17]=8'h3C, data_addr=17, kind=01 -> mdr=8'h3C at T+3; ir keeps its prior value; mem_write never asserted.
- Store then fetch:
  - kind=10, data_addr=9, store_data=8'h7E -> mem_write high exactly one cycle at T+2 with address 9.
  - Then fetch pc=9 starting at T+4 -> ir=8'h7E at T+7.
- Ignored requests:
  - start held high through a load -> exactly one request; busy pattern 1,1,1,0 after T.
  - start with kind=11 -> no strobes, no done, busy stays 0.
- Reset mid-op: rst asserted during ACCESS of a load to address 4 -> next cycle state IDLE, strobes 0, mdr=0, done never pulses; a fresh fetch afterwards completes normally.
- Input churn: change pc from 5 to 6 during SETUP of a fetch -> mem_address stays 5 through CAPTURE; ir = memory[5].

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory access sequencer: access kinds, FSM states, default widths.
// Latency: none (definitions only); backpressure: n/a.
package mem_access_unit_pkg;

  localparam int unsigned WORD_DEFAULT     = 8;
  localparam int unsigned ADDRESSL_DEFAULT = 5;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'b00,
    KIND_LOAD  = 2'b01,
    KIND_STORE = 2'b10,
    KIND_RSVD  = 2'b11
  } kind_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_SETUP   = 2'b01,
    S_ACCESS  = 2'b10,
    S_CAPTURE = 2'b11
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Controller request/response and memory bus bundle for mem_access_unit.
// Latency: none (wiring); backpressure: start is only honoured while busy is low.
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WORD     = WORD_DEFAULT,
  parameter int unsigned ADDRESSL = ADDRESSL_DEFAULT
);
  logic                start;
  logic [1:0]          kind;
  logic [ADDRESSL-1:0] pc;
  logic [ADDRESSL-1:0] data_addr;
  logic [WORD-1:0]     store_data;
  logic [WORD-1:0]     ir;
  logic [WORD-1:0]     mdr;
  logic                busy;
  logic                done;

  logic [ADDRESSL-1:0] mem_address;
  logic [WORD-1:0]     mem_write_data;
  logic                mem_read;
  logic                mem_write;
  logic [WORD-1:0]     mem_read_data;

  // The sequencer is the slave of the controller and drives the memory side.
  modport slave (
    input  start, kind, pc, data_addr, store_data, mem_read_data,
    output ir, mdr, busy, done, mem_address, mem_write_data, mem_read, mem_write
  );

  modport master (
    output start, kind, pc, data_addr, store_data, mem_read_data,
    input  ir, mdr, busy, done, mem_address, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Sequences one fetch/load/store per request: SETUP, one-cycle strobe in ACCESS, done in CAPTURE.
// Latency: done 3 cycles after the accepting edge; backpressure: start ignored while busy.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WORD     = WORD_DEFAULT,
  parameter int unsigned ADDRESSL = ADDRESSL_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  mem_access_unit_if.slave bus
);

  state_t              r_state;
  state_t              w_next;
  kind_t               r_kind;
  logic [ADDRESSL-1:0] r_addr;
  logic [WORD-1:0]     r_wdata;
  logic [WORD-1:0]     r_ir;
  logic [WORD-1:0]     r_mdr;

  logic w_accept;
  logic w_mem_read;
  logic w_mem_write;
  logic w_busy;
  logic w_done;

  assign w_accept = (r_state == S_IDLE) && bus.start && (kind_t'(bus.kind) != KIND_RSVD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_SETUP;
      S_SETUP:   w_next = S_ACCESS;
      S_ACCESS:  w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Strobes depend only on registered state/kind, so the address is settled a full cycle before.
  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_busy      = (r_state != S_IDLE);
    w_done      = (r_state == S_CAPTURE);
    if (r_state == S_ACCESS) begin
      w_mem_read  = (r_kind != KIND_STORE);
      w_mem_write = (r_kind == KIND_STORE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind  <= KIND_FETCH;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ir    <= '0;
      r_mdr   <= '0;
    end else begin
      if (w_accept) begin
        r_kind <= kind_t'(bus.kind);
        r_addr <= (kind_t'(bus.kind) == KIND_FETCH) ? bus.pc : bus.data_addr;
        if (kind_t'(bus.kind) == KIND_STORE) begin
          r_wdata <= bus.store_data;
        end
      end
      if (r_state == S_ACCESS) begin
        if (r_kind == KIND_FETCH) begin
          r_ir <= bus.mem_read_data;
        end else if (r_kind == KIND_LOAD) begin
          r_mdr <= bus.mem_read_data;
        end
      end
    end
  end

  assign bus.mem_address    = r_addr;
  assign bus.mem_write_data = r_wdata;
  assign bus.mem_read       = w_mem_read;
  assign bus.mem_write      = w_mem_write;
  assign bus.ir             = r_ir;
  assign bus.mdr            = r_mdr;
  assign bus.busy           = w_busy;
  assign bus.done           = w_done;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 32x8 asynchronous-read memory.
module tb_mem_access_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] mem [32];

  mem_access_unit_if #(.WORD(8), .ADDRESSL(5)) bus ();

  mem_access_unit #(.WORD(8), .ADDRESSL(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_address];

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {bus.mem_read, bus.mem_write}); end
    checks++; if (bus.ir !== 8'h00 || bus.mdr !== 8'h00) begin errors++; $display("FAIL reset_ir_mdr: got %h/%h want 00/00", bus.ir, bus.mdr); end
    checks++; if (bus.mem_address !== 5'd0 || bus.mem_write_data !== 8'h00) begin errors++; $display("FAIL reset_addr_wdata: got %0d/%h want 0/00", bus.mem_address, bus.mem_write_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    mem[3] = 8'hA5;
    bus.pc = 5'd3; bus.data_addr = 5'd0; bus.kind = 2'b00; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL fetch_setup: got busy=%b rd=%b wr=%b want 1 0 0", bus.busy, bus.mem_read, bus.mem_write); end
    checks++; if (bus.mem_address !== 5'd3) begin errors++; $display("FAIL fetch_setup_addr: got %0d want 3", bus.mem_address); end
    tick();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL fetch_access: got rd=%b wr=%b done=%b want 1 0 0", bus.mem_read, bus.mem_write, bus.done); end
    checks++; if (bus.mem_address !== 5'd3) begin errors++; $display("FAIL fetch_access_addr: got %0d want 3", bus.mem_address); end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL fetch_capture: got done=%b rd=%b want 1 0", bus.done, bus.mem_read); end
    checks++; if (bus.ir !== 8'hA5 || bus.mdr !== 8'h00) begin errors++; $display("FAIL fetch_ir_mdr: got %h/%h want a5/00", bus.ir, bus.mdr); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL fetch_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_load();
    logic wr_seen;
    wr_seen = 1'b0;
    mem[17] = 8'h3C;
    bus.data_addr = 5'd17; bus.kind = 2'b01; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (bus.mem_write) wr_seen = 1'b1;
      if (c == 2) begin
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 5'd17) begin errors++; $display("FAIL load_access: got rd=%b addr=%0d want 1 17", bus.mem_read, bus.mem_address); end
      end
      if (c == 3) begin
        checks++; if (bus.mdr !== 8'h3C || bus.ir !== 8'hA5 || bus.done !== 1'b1) begin errors++; $display("FAIL load_capture: got mdr=%h ir=%h done=%b want 3c a5 1", bus.mdr, bus.ir, bus.done); end
      end
      if (c < 4) tick();
    end
    checks++; if (wr_seen !== 1'b0) begin errors++; $display("FAIL load_no_write: got %b want 0", wr_seen); end
  endtask

  task automatic test_store_fetch();
    mem[9] = 8'h00;
    bus.kind = 2'b10; bus.data_addr = 5'd9; bus.store_data = 8'h7E; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.mem_write !== 1'b0 || bus.mem_address !== 5'd9) begin errors++; $display("FAIL store_setup: got wr=%b addr=%0d want 0 9", bus.mem_write, bus.mem_address); end
    tick();
    checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_address !== 5'd9 || bus.mem_write_data !== 8'h7E) begin errors++; $display("FAIL store_access: got wr=%b rd=%b addr=%0d wd=%h want 1 0 9 7e", bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_write_data); end
    tick();
    checks++; if (bus.mem_write !== 1'b0 || bus.done !== 1'b1 || bus.ir !== 8'hA5 || bus.mdr !== 8'h3C) begin errors++; $display("FAIL store_capture: got wr=%b done=%b ir=%h mdr=%h want 0 1 a5 3c", bus.mem_write, bus.done, bus.ir, bus.mdr); end
    checks++; if (mem[9] !== 8'h7E) begin errors++; $display("FAIL store_mem: got %h want 7e", mem[9]); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL store_idle: got busy=%b want 0", bus.busy); end
    bus.kind = 2'b00; bus.pc = 5'd9; bus.store_data = 8'h00; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    checks++; if (bus.ir !== 8'h7E || bus.done !== 1'b1) begin errors++; $display("FAIL store_then_fetch: got ir=%h done=%b want 7e 1", bus.ir, bus.done); end
    checks++; if (bus.mem_write_data !== 8'h7E) begin errors++; $display("FAIL fetch_keeps_wdata: got %h want 7e", bus.mem_write_data); end
    tick();
  endtask

  task automatic test_ignored_busy();
    logic [3:0] bp;
    int rd_cnt;
    int dn_cnt;
    rd_cnt = 0; dn_cnt = 0; bp = 4'b0000;
    mem[20] = 8'h11;
    bus.kind = 2'b01; bus.data_addr = 5'd20; bus.start = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (bus.mem_read) rd_cnt++;
      if (bus.done) dn_cnt++;
      bp[4-c] = bus.busy;
      if (c == 4) bus.start = 1'b0;
      tick();
    end
    checks++; if (bp !== 4'b1110) begin errors++; $display("FAIL busy_pattern: got %b want 1110", bp); end
    checks++; if (rd_cnt != 1 || dn_cnt != 1) begin errors++; $display("FAIL single_request: got rd=%0d done=%0d want 1 1", rd_cnt, dn_cnt); end
    checks++; if (bus.busy !== 1'b0 || bus.mdr !== 8'h11) begin errors++; $display("FAIL after_held_start: got busy=%b mdr=%h want 0 11", bus.busy, bus.mdr); end
  endtask

  task automatic test_rsvd();
    logic act;
    act = 1'b0;
    bus.kind = 2'b11; bus.pc = 5'd1; bus.data_addr = 5'd2; bus.start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.busy || bus.mem_read || bus.mem_write || bus.done) act = 1'b1;
    end
    bus.start = 1'b0;
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL rsvd_activity: got %b want 0", act); end
    checks++; if (bus.ir !== 8'h7E || bus.mdr !== 8'h11 || bus.mem_address !== 5'd20) begin errors++; $display("FAIL rsvd_state: got ir=%h mdr=%h addr=%0d want 7e 11 20", bus.ir, bus.mdr, bus.mem_address); end
  endtask

  task automatic test_reset_mid();
    logic dn_seen;
    dn_seen = 1'b0;
    mem[4] = 8'h44;
    bus.kind = 2'b01; bus.data_addr = 5'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL rstmid_access: got rd=%b want 1", bus.mem_read); end
    rst = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy=%b rd=%b wr=%b done=%b want 0 0 0 0", bus.busy, bus.mem_read, bus.mem_write, bus.done); end
    checks++; if (bus.mdr !== 8'h00 || bus.ir !== 8'h00 || bus.mem_address !== 5'd0) begin errors++; $display("FAIL rstmid_regs: got mdr=%h ir=%h addr=%0d want 00 00 0", bus.mdr, bus.ir, bus.mem_address); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.done) dn_seen = 1'b1;
    end
    checks++; if (dn_seen !== 1'b0 || bus.mdr !== 8'h00) begin errors++; $display("FAIL rstmid_abandon: got done=%b mdr=%h want 0 00", dn_seen, bus.mdr); end
    bus.kind = 2'b00; bus.pc = 5'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    checks++; if (bus.ir !== 8'hA5 || bus.done !== 1'b1) begin errors++; $display("FAIL rstmid_refetch: got ir=%h done=%b want a5 1", bus.ir, bus.done); end
    tick();
  endtask

  task automatic test_churn();
    mem[5] = 8'h55; mem[6] = 8'h66;
    bus.kind = 2'b00; bus.pc = 5'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.pc = 5'd6;
    checks++; if (bus.mem_address !== 5'd5) begin errors++; $display("FAIL churn_setup_addr: got %0d want 5", bus.mem_address); end
    tick();
    checks++; if (bus.mem_address !== 5'd5 || bus.mem_read !== 1'b1) begin errors++; $display("FAIL churn_access: got addr=%0d rd=%b want 5 1", bus.mem_address, bus.mem_read); end
    tick();
    checks++; if (bus.mem_address !== 5'd5 || bus.ir !== 8'h55) begin errors++; $display("FAIL churn_capture: got addr=%0d ir=%h want 5 55", bus.mem_address, bus.ir); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.mem_address !== 5'd5) begin errors++; $display("FAIL churn_idle: got busy=%b addr=%0d want 0 5", bus.busy, bus.mem_address); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.kind = 2'b00; bus.pc = '0; bus.data_addr = '0; bus.store_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    test_reset();
    test_fetch();
    test_load();
    test_store_fetch();
    test_ignored_busy();
    test_rsvd();
    test_reset_mid();
    test_churn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
